mixcolumns_engine: RTL
======================

MIXCOLUMNS_ENGINE -- requirements
Module: mixcolumns_engine

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1, columns processed per cycle; legal values 1, 2, 4.
REQ-002 Parameter HOLD_ON_STALL, default 1; 1 = result held in output register while out_ready low, 0 = identical behaviour (reserved), no other use.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data/in_inv hold a block.
REQ-006 in_ready  output  1  engine accepts a block this cycle.
REQ-007 in_data  input  128  AES state; column c = bits [127-32c : 96-32c], first byte of a column in its MSBs.
REQ-008 in_inv  input  1  1 = InvMixColumns, 0 = MixColumns; sampled with the block.
REQ-009 out_valid  output  1  out_data holds a finished block.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 out_data  output  128  transformed state, same column/byte layout as in_data.
REQ-012 busy  output  1  high in state BUSY.

Function
REQ-013 FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-014 IDLE: in_valid & in_ready -> capture in_data and in_inv into a 128-bit working register, clear column counter, go to BUSY.
REQ-015 BUSY: each cycle transform COLS_PER_CYCLE columns, starting at column 0, in place in the working register; counter advances by COLS_PER_CYCLE.
REQ-016 BUSY -> DONE on the cycle the last column group (index 4-COLS_PER_CYCLE) is written; counter wraps to 0.
REQ-017 Latency: accept at edge t -> out_valid high after edge t+4/COLS_PER_CYCLE (4, 2 or 1 cycles).
REQ-018 DONE: out_data = working register, stable while out_valid & !out_ready; out_valid & out_ready -> IDLE next edge.
REQ-019 No new block accepted in the cycle out_ready completes a transfer; in_ready rises the following cycle (throughput one block per 4/COLS_PER_CYCLE+2 cycles).
REQ-020 Inverse column transform: rows {0e,0b,0d,09} rotated, GF(2^8) with polynomial 0x11B.
REQ-021 Forward column transform: rows {02,03,01,01} rotated, same field.
REQ-022 GF multiplies built from xtime chains; no lookup tables; all arithmetic 8-bit, no carries beyond bit 7.
REQ-023 in_valid while not IDLE is ignored; in_data/in_inv changes after acceptance do not affect the block in flight.
REQ-024 Illegal COLS_PER_CYCLE fails elaboration.

Reset
REQ-025 rst_n low -> state IDLE, counter 0, working register 0, mode bit 0, immediately and regardless of clk.
REQ-026 Reset values: in_ready 1 after release, out_valid 0, busy 0, out_data 0.
REQ-027 Reset during BUSY or DONE discards the block; no partial result ever presented.

Configuration
REQ-028 Macro MIXCOL_FWD_EN defined: forward and inverse datapaths built, in_inv selects per block.
REQ-029 MIXCOL_FWD_EN undefined: forward datapath omitted, in_inv ignored, every block gets InvMixColumns.

Verification
REQ-030 MIXCOL_FWD_EN, in_inv=0, in_data=db135345_f20a225c_01010101_c6c6c6c6 -> out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
REQ-031 in_inv=1, in_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> out_data=db135345_f20a225c_01010101_c6c6c6c6, both macro settings.
REQ-032 COLS_PER_CYCLE=1,2,4: accept at edge t -> out_valid first high after edge t+4, t+2, t+1 respectively; busy high exactly 4, 2, 1 cycles.
REQ-033 out_ready held low 10 cycles in DONE -> out_data and out_valid stable, in_ready 0, second in_valid ignored; out_ready high -> IDLE, in_ready 1 next cycle.
REQ-034 rst_n pulsed low mid-BUSY -> out_valid 0, in_ready 1 after release, next block (all 0x01) -> out_data all 0x01.
REQ-035 MIXCOL_FWD_EN undefined, in_inv=0, in_data=8e4da1bc repeated 4x -> out_data=db135345 repeated 4x.

Source files
------------

// File: rtl/mixcolumns_engine.sv
// -----------------------------------------------------------------------------
// mixcolumns_engine
//
// Applies AES InvMixColumns (and, optionally, MixColumns) to a 128-bit state.
// A block is captured into a working register, transformed in place
// COLS_PER_CYCLE columns per cycle, then held on the output until consumed.
//
// Parameters
//   COLS_PER_CYCLE : columns transformed per cycle (1, 2 or 4)
//   HOLD_ON_STALL  : reserved, must be 0 or 1; the result is always held
//
// Configuration macro
//   MIXCOL_FWD_EN  : defined   -> forward and inverse datapaths, in_inv selects
//                    undefined -> inverse datapath only, in_inv ignored
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_data/in_inv hold a block
//   in_ready  : engine is idle and accepts a block
//   in_data   : AES state, column c = bits [127-32c : 96-32c], byte 0 in MSBs
//   in_inv    : 1 = InvMixColumns, 0 = MixColumns (sampled with the block)
//   out_valid : out_data holds a finished block
//   out_ready : consumer accepts out_data
//   out_data  : transformed state (zero whenever out_valid is low)
//   busy      : transform in progress
// -----------------------------------------------------------------------------
module mixcolumns_engine #(
   parameter int COLS_PER_CYCLE = 1,
   parameter int HOLD_ON_STALL  = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4))
   begin : g_bad_cols
      $error("mixcolumns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
   end
   if (!(HOLD_ON_STALL == 0 || HOLD_ON_STALL == 1)) begin : g_bad_hold
      $error("mixcolumns_engine: HOLD_ON_STALL must be 0 or 1");
   end

   localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
   localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t       state_q, state_d;
   logic [1:0]   col_q, col_d;
   logic [127:0] work_q, work_d;
   logic         inv_q, inv_d;

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [7:0] a, x2, x4, x8;
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int i = 0; i < 4; i++) begin
         a     = c[31-8*i -: 8];
         x2    = xtime(a);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a;
         mb[i] = x8 ^ x2 ^ a;
         md[i] = x8 ^ x4 ^ a;
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

`ifdef MIXCOL_FWD_EN
   function automatic logic [31:0] fwd_col(input logic [31:0] c);
      logic [7:0] a  [4];
      logic [7:0] m2 [4];
      logic [7:0] m3 [4];
      for (int i = 0; i < 4; i++) begin
         a[i]  = c[31-8*i -: 8];
         m2[i] = xtime(a[i]);
         m3[i] = m2[i] ^ a[i];
      end
      return {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
              a[0]  ^ m2[1] ^ m3[2] ^ a[3],
              a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
              m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
   endfunction
`else
   // Mode input has no effect when only the inverse datapath is built.
   logic unused_inv;
   assign unused_inv = in_inv;
`endif

   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d = state_q;
      col_d   = col_q;
      work_d  = work_q;
      inv_d   = inv_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = BUSY;
               col_d   = '0;
               work_d  = in_data;
               inv_d   = in_inv;
            end
         end
         BUSY: begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
`ifdef MIXCOL_FWD_EN
               work_d[127-32*(int'(col_q)+g) -: 32] = inv_q
                  ? inv_col(work_q[127-32*(int'(col_q)+g) -: 32])
                  : fwd_col(work_q[127-32*(int'(col_q)+g) -: 32]);
`else
               work_d[127-32*(int'(col_q)+g) -: 32] =
                  inv_col(work_q[127-32*(int'(col_q)+g) -: 32]);
`endif
            end
            col_d = col_q + COL_STEP;   // 2-bit counter wraps to 0 after the last group
            if (col_q == LAST_COL) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         col_q   <= '0;
         // NOTE: the wide working register is reset too, so an aborted block
         // leaves no residue that could ever reach the output.
         work_q  <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         work_q  <= work_d;
         inv_q   <= inv_d;
      end
   end

`ifndef MIXCOL_FWD_EN
   logic unused_mode;
   assign unused_mode = inv_q;
`endif

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == BUSY);
   assign out_valid = (state_q == DONE);
   // Partially transformed data never leaves the engine.
   assign out_data  = out_valid ? work_q : '0;

endmodule
